// File: rtl/rx_pkt_ctrl_pkg.sv
// Shared definitions for the RX packet sequencer: FSM encoding and the
// packet-count width used by the RX datapath.
package rx_pkt_ctrl_pkg;

    localparam int RX_NB_PKG_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SEARCH = 3'd2,
        ST_RECV   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/rx_pkt_ctrl_tmo.sv
// Loadable down-counter for the AA-search / inter-byte timeout.
// A loaded value of zero never expires; expire pulses when an enabled count sits at 1.
module rx_pkt_tmo #(
    parameter int TMO_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMO_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == TMO_W'(1));

endmodule

// File: rtl/rx_pkt_ctrl.sv
// Packet-level RX sequencer: arms the RX datapath, waits for the access address,
// drains LEN bytes from the RX FIFO into a valid/ready stream and samples the CRC.
module rx_pkt_ctrl
    import rx_pkt_ctrl_pkg::*;
#(
    parameter int LEN_W    = RX_NB_PKG_W,
    parameter int TMO_W    = 20,
    parameter int CRC_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             rx_start,
    output logic             rx_en,
    output logic [LEN_W-1:0] rx_nb_pkg,
    input  logic             rx_aa_found,
    input  logic             rx_empty,
    output logic             rx_rd_en,
    input  logic [7:0]       rx_data,
    input  logic             rx_crc_valid,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             timeout,
    output logic [LEN_W-1:0] byte_cnt
);

    localparam int CHK_W = $clog2(CRC_WAIT + 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             rd_pend_q, rd_pend_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             crc_ok_q, crc_ok_d;
    logic             timeout_q, timeout_d;
    logic             tmo_load, tmo_en, tmo_expire;
    logic             rd_ok, rd_en, accept, last_acc;

    rx_pkt_tmo #(.TMO_W(TMO_W)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load),
        .load_val (tmo_q),
        .en       (tmo_en),
        .expire   (tmo_expire)
    );

    // A read may issue only when nothing is in flight and the output register frees up this cycle.
    assign accept   = out_valid_q && out_ready;
    assign last_acc = accept && ((byte_cnt_q + LEN_W'(1)) == len_q);
    assign rd_ok    = (state_q == ST_RECV) && !rd_pend_q && (!out_valid_q || out_ready)
                      && (rd_cnt_q < len_q);
    assign rd_en    = rd_ok && !rx_empty && !cmd_abort;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        tmo_d       = tmo_q;
        rd_cnt_d    = rd_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        chk_d       = chk_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rd_pend_d   = rd_en;
        done_d      = done_q;
        crc_ok_d    = crc_ok_q;
        timeout_d   = timeout_q;
        tmo_load    = 1'b0;
        tmo_en      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cmd_start) begin
                    len_d      = cfg_len;
                    tmo_d      = cfg_timeout;
                    done_d     = 1'b0;
                    crc_ok_d   = 1'b0;
                    timeout_d  = 1'b0;
                    byte_cnt_d = '0;
                    rd_cnt_d   = '0;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                tmo_load = 1'b1;
                state_d  = ST_SEARCH;
            end
            ST_SEARCH: begin
                tmo_en = 1'b1;
                if (rx_aa_found) begin
                    tmo_load = 1'b1;
                    chk_d    = CHK_W'(CRC_WAIT - 1);
                    state_d  = (len_q == '0) ? ST_CHECK : ST_RECV;
                end else if (tmo_expire) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_RECV: begin
                // Only starvation on an empty FIFO counts toward the inter-byte timeout.
                tmo_en = rd_ok && rx_empty;
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + LEN_W'(1);
                end
                if (rd_pend_q) begin
                    out_data_d  = rx_data;
                    out_valid_d = 1'b1;
                    tmo_load    = 1'b1;
                end else if (accept) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                end
                if (last_acc) begin
                    chk_d   = CHK_W'(CRC_WAIT - 1);
                    state_d = ST_CHECK;
                end else if (tmo_expire) begin
                    out_valid_d = 1'b0;
                    rd_pend_d   = 1'b0;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_CHECK: begin
                if (chk_q == '0) begin
                    crc_ok_d = rx_crc_valid;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    chk_d = chk_q - CHK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmd_abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            rd_pend_d   = 1'b0;
            done_d      = 1'b0;
            crc_ok_d    = 1'b0;
            timeout_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            tmo_q       <= '0;
            rd_cnt_q    <= '0;
            byte_cnt_q  <= '0;
            chk_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tmo_q       <= tmo_d;
            rd_cnt_q    <= rd_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            chk_q       <= chk_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rd_pend_q   <= rd_pend_d;
            done_q      <= done_d;
            crc_ok_q    <= crc_ok_d;
            timeout_q   <= timeout_d;
        end
    end

    assign rx_start  = (state_q == ST_ARM);
    assign rx_en     = (state_q inside {ST_SEARCH, ST_RECV, ST_CHECK});
    assign busy      = !(state_q inside {ST_IDLE, ST_DONE});
    assign rx_nb_pkg = len_q;
    assign rx_rd_en  = rd_en;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign crc_ok    = crc_ok_q;
    assign timeout   = timeout_q;
    assign byte_cnt  = byte_cnt_q;

endmodule
